// File: rtl/parity_frame_checker_if.sv
// Stream-side and result-side handshake bundle for parity_frame_checker.
// The err_count signal only exists when PARITY_ERR_COUNT_EN is defined.
interface parity_frame_checker_if #(
   parameter int WIDTH     = 8,
   parameter int MAX_BEATS = 16
);
   localparam int CNT_W = $clog2(MAX_BEATS + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             in_parity;
   logic             mode_odd;

   logic             out_valid;
   logic             out_ready;
   logic             out_parity;
   logic             out_error;
   logic             out_trunc;
   logic [CNT_W-1:0] out_beats;
`ifdef PARITY_ERR_COUNT_EN
   logic [15:0]      err_count;
`endif

   // The source/consumer side drives beats and acknowledges results.
   modport master (
      output in_valid, in_data, in_last, in_parity, mode_odd, out_ready,
`ifdef PARITY_ERR_COUNT_EN
      input  err_count,
`endif
      input  in_ready, out_valid, out_parity, out_error, out_trunc, out_beats
   );

   // The checker accepts beats and presents one result per frame.
   modport slave (
      input  in_valid, in_data, in_last, in_parity, mode_odd, out_ready,
`ifdef PARITY_ERR_COUNT_EN
      output err_count,
`endif
      output in_ready, out_valid, out_parity, out_error, out_trunc, out_beats
   );
endinterface

// File: rtl/parity_frame_checker.sv
// Accumulates even/odd parity across a multi-beat frame and reports one checked result per frame.
// Optional feature macro PARITY_ERR_COUNT_EN adds a saturating count of errored results.
module parity_frame_checker #(
   parameter int WIDTH     = 8,
   parameter int MAX_BEATS = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   parity_frame_checker_if.slave  bus
);
   localparam int               CNT_W   = $clog2(MAX_BEATS + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      RESULT
   } frameState_t;

   frameState_t      state_q, state_d;
   logic             acc_q, acc_d;
   logic             mode_q, mode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             outParity_q, outParity_d;
   logic             outError_q, outError_d;
   logic             outTrunc_q, outTrunc_d;
   logic [CNT_W-1:0] outBeats_q, outBeats_d;
`ifdef PARITY_ERR_COUNT_EN
   logic [15:0]      errCount_q, errCount_d;
`endif

   logic accept;
   logic beatParity;
   logic closeFrame;

   assign accept     = bus.in_valid && (state_q != RESULT);
   assign beatParity = ^bus.in_data;

   // Next-state logic: the result registers are loaded on the beat that closes
   // the frame, so the result is visible the cycle after that beat is accepted.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      mode_d      = mode_q;
      cnt_d       = cnt_q;
      outParity_d = outParity_q;
      outError_d  = outError_q;
      outTrunc_d  = outTrunc_q;
      outBeats_d  = outBeats_q;
      closeFrame  = 1'b0;
`ifdef PARITY_ERR_COUNT_EN
      errCount_d  = errCount_q;
`endif

      case (state_q)
         IDLE: begin
            if (accept) begin
               mode_d     = bus.mode_odd;
               acc_d      = beatParity;
               cnt_d      = CNT_ONE;
               closeFrame = bus.in_last || (CNT_ONE == CNT_MAX);
               state_d    = ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               acc_d      = acc_q ^ beatParity;
               cnt_d      = cnt_q + CNT_ONE;
               closeFrame = bus.in_last || (cnt_d == CNT_MAX);
            end
         end
         RESULT: begin
            if (bus.out_ready) begin
               state_d = IDLE;
`ifdef PARITY_ERR_COUNT_EN
               if (outError_q && (errCount_q != 16'hFFFF)) begin
                  errCount_d = errCount_q + 16'd1;
               end
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A frame closed by hitting MAX_BEATS has no expected parity to compare.
      if (closeFrame) begin
         state_d     = RESULT;
         outParity_d = acc_d ^ mode_d;
         outError_d  = bus.in_last && (outParity_d != bus.in_parity);
         outTrunc_d  = !bus.in_last;
         outBeats_d  = cnt_d;
      end
   end

   // State and result registers with synchronous reset; reset discards any open or pending frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         acc_q       <= 1'b0;
         mode_q      <= 1'b0;
         cnt_q       <= '0;
         outParity_q <= 1'b0;
         outError_q  <= 1'b0;
         outTrunc_q  <= 1'b0;
         outBeats_q  <= '0;
`ifdef PARITY_ERR_COUNT_EN
         errCount_q  <= 16'd0;
`endif
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         mode_q      <= mode_d;
         cnt_q       <= cnt_d;
         outParity_q <= outParity_d;
         outError_q  <= outError_d;
         outTrunc_q  <= outTrunc_d;
         outBeats_q  <= outBeats_d;
`ifdef PARITY_ERR_COUNT_EN
         errCount_q  <= errCount_d;
`endif
      end
   end

   // in_ready depends only on registered state, so out_ready never reaches it combinationally.
   assign bus.in_ready   = (state_q != RESULT);
   assign bus.out_valid  = (state_q == RESULT);
   assign bus.out_parity = outParity_q;
   assign bus.out_error  = outError_q;
   assign bus.out_trunc  = outTrunc_q;
   assign bus.out_beats  = outBeats_q;
`ifdef PARITY_ERR_COUNT_EN
   assign bus.err_count  = errCount_q;
`endif

endmodule
